arm_motion_sequencer: RTL and testbench

Plays back arm poses from the position memory, or follows the accelerometer live, and drives the X/Y/Z targets that feed the servo PWM, VGA and display paths. All axis changes are slew-limited, so servos never jump: each tick, each axis moves at most MAX_STEP toward its target. In playback it fetches one pose per step, ramps to it, dwells, then advances. It replaces the direct memory/accelerometer mux in front of pwm_servos.

---
 rtl/arm_motion_sequencer.sv | 168 ++++++++++++++++
 tb/tb_arm_motion_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_motion_sequencer.sv
// rtl/arm_motion_sequencer.sv - slew-limited pose playback / live-follow sequencer for the X/Y/Z servo targets
module arm_motion_sequencer #(
    parameter int DATA_WIDTH    = 30,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_POINTS    = 16,
    parameter int CLK_FREQ      = 50_000_000,
    parameter int TICK_HZ       = 1000,
    parameter int MAX_STEP      = 4,
    parameter int DWELL_TICKS   = 500,
    parameter int HOME_POS      = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     select_source,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_rd_en,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic [9:0]               accel_x,
    input  logic [9:0]               accel_y,
    input  logic [9:0]               accel_z,
    output logic [9:0]               x_out,
    output logic [9:0]               y_out,
    output logic [9:0]               z_out,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               state_dbg
);
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
    localparam logic signed [11:0] STEP_S = 12'(MAX_STEP);
    localparam logic [9:0]         STEP_U = 10'(MAX_STEP);
    localparam logic [9:0]         HOME   = 10'(HOME_POS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_RAMP  = 3'd3,
        S_DWELL = 3'd4,
        S_DONE  = 3'd5,
        S_LIVE  = 3'd6
    } state_t;

    state_t            state, next_state;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [DW-1:0]     dwell_cnt;
    logic [9:0]        tgt_x, tgt_y, tgt_z;
    logic [9:0]        eff_x, eff_y, eff_z;
    logic              abort, at_target, dwell_done, last_point, slew_en;

    // One slew step; stepping toward an in-range target can never leave 0..1023.
    function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        if (diff > STEP_S)
            slew = cur + STEP_U;
        else if (diff < -STEP_S)
            slew = cur - STEP_U;
        else
            slew = tgt;
    endfunction

    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
    assign abort      = stop | select_source;
    assign at_target  = (x_out == tgt_x) && (y_out == tgt_y) && (z_out == tgt_z);
    assign dwell_done = (dwell_cnt == DW'(DWELL_TICKS));
    assign last_point = (mem_addr == ADDRESS_WIDTH'(NUM_POINTS - 1));
    assign slew_en    = tick && (((state == S_RAMP) && !abort) ||
                                 ((state == S_LIVE) && select_source));

    // Live mode follows the accelerometer without a cycle of target lag.
    assign eff_x = (state == S_LIVE) ? accel_x : tgt_x;
    assign eff_y = (state == S_LIVE) ? accel_y : tgt_y;
    assign eff_z = (state == S_LIVE) ? accel_z : tgt_z;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (select_source)
                    next_state = S_LIVE;
                else if (start && !stop)
                    next_state = S_FETCH;
            end
            S_FETCH: next_state = abort ? S_IDLE : S_WAIT;
            S_WAIT:  next_state = abort ? S_IDLE : S_RAMP;
            S_RAMP: begin
                if (abort)
                    next_state = S_IDLE;
                else if (at_target)
                    next_state = S_DWELL;
            end
            S_DWELL: begin
                if (abort)
                    next_state = S_IDLE;
                else if (dwell_done)
                    next_state = last_point ? S_DONE : S_FETCH;
            end
            S_DONE:  next_state = S_IDLE;
            S_LIVE: begin
                if (!select_source)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = (state == S_FETCH);
        done      = (state == S_DONE);
        busy      = (state == S_FETCH) || (state == S_WAIT) || (state == S_RAMP) ||
                    (state == S_DWELL) || (state == S_LIVE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            dwell_cnt <= '0;
            mem_addr  <= '0;
            tgt_x     <= HOME;
            tgt_y     <= HOME;
            tgt_z     <= HOME;
            x_out     <= HOME;
            y_out     <= HOME;
            z_out     <= HOME;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

            if ((state == S_IDLE) && (next_state == S_FETCH))
                mem_addr <= '0;
            else if ((state == S_DWELL) && (next_state == S_FETCH))
                mem_addr <= mem_addr + ADDRESS_WIDTH'(1);

            if ((state == S_WAIT) && (next_state == S_RAMP)) begin
                tgt_x <= mem_data[29:20];
                tgt_y <= mem_data[19:10];
                tgt_z <= mem_data[9:0];
            end else if (state == S_LIVE) begin
                tgt_x <= accel_x;
                tgt_y <= accel_y;
                tgt_z <= accel_z;
            end

            if ((state == S_RAMP) && (next_state == S_DWELL))
                dwell_cnt <= '0;
            else if ((state == S_DWELL) && tick && !dwell_done)
                dwell_cnt <= dwell_cnt + DW'(1);

            if (slew_en) begin
                x_out <= slew(x_out, eff_x);
                y_out <= slew(y_out, eff_y);
                z_out <= slew(z_out, eff_z);
            end
        end
    end
endmodule

// File: tb/tb_arm_motion_sequencer.sv
// tb/tb_arm_motion_sequencer.sv - directed and randomized bench for arm_motion_sequencer
module tb_arm_motion_sequencer;
    localparam int TD = 10;
    localparam int MS = 4;
    localparam int DT = 2;
    localparam int NP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, select_source = 1'b0;
    logic [3:0]  mem_addr;
    logic        mem_rd_en;
    logic [29:0] mem_data = '0;
    logic [9:0]  accel_x = 10'd512, accel_y = 10'd512, accel_z = 10'd512;
    logic [9:0]  x_out, y_out, z_out;
    logic        busy, done;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    logic [29:0] mem [16];

    always #5 clk = ~clk;

    arm_motion_sequencer #(
        .DATA_WIDTH(30), .ADDRESS_WIDTH(4), .NUM_POINTS(NP), .CLK_FREQ(100),
        .TICK_HZ(10), .MAX_STEP(MS), .DWELL_TICKS(DT), .HOME_POS(512)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .select_source(select_source),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Synchronous-read pose memory: data appears one cycle after the strobe.
    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

    // Reference model: phase number, pose index, dwell ticks and axis positions.
    bit m_valid = 0;
    int m_state = 0, m_addr = 0, m_dwell = 0, m_cnt = 0, m_ticks = 0;
    int m_out[3], m_tgt[3];

    function automatic int step_toward(input int o, input int t);
        int d;
        d = t - o;
        if (d > MS) return o + MS;
        if (d < -MS) return o - MS;
        return t;
    endfunction

    always @(posedge clk) begin
        bit tk, ab;
        logic [29:0] w;
        int acc[3];
        if (rst) begin
            m_valid = 1; m_state = 0; m_addr = 0; m_dwell = 0; m_cnt = 0;
            for (int i = 0; i < 3; i++) begin m_out[i] = 512; m_tgt[i] = 512; end
        end else if (m_valid) begin
            tk = (m_cnt == TD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) m_ticks++;
            ab = stop || select_source;
            acc[0] = accel_x; acc[1] = accel_y; acc[2] = accel_z;
            case (m_state)
                0: if (select_source) m_state = 6;
                   else if (start && !stop) begin m_addr = 0; m_state = 1; end
                1: m_state = ab ? 0 : 2;
                2: if (ab) m_state = 0;
                   else begin
                       w = mem[m_addr];
                       m_tgt[0] = w[29:20]; m_tgt[1] = w[19:10]; m_tgt[2] = w[9:0];
                       m_state = 3;
                   end
                3: if (ab) m_state = 0;
                   else begin
                       if (m_out[0] == m_tgt[0] && m_out[1] == m_tgt[1] && m_out[2] == m_tgt[2]) begin
                           m_dwell = 0; m_state = 4;
                       end
                       if (tk) for (int i = 0; i < 3; i++) m_out[i] = step_toward(m_out[i], m_tgt[i]);
                   end
                4: if (ab) m_state = 0;
                   else if (m_dwell == DT) begin
                       if (m_addr == NP - 1) m_state = 5;
                       else begin m_addr++; m_state = 1; end
                   end else if (tk) m_dwell++;
                5: m_state = 0;
                default: begin
                    for (int i = 0; i < 3; i++) m_tgt[i] = acc[i];
                    if (!select_source) m_state = 0;
                    else if (tk) for (int i = 0; i < 3; i++) m_out[i] = step_toward(m_out[i], acc[i]);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [39:0] exp_v, act_v;
        if (m_valid) begin
            exp_v = {10'(m_out[0]), 10'(m_out[1]), 10'(m_out[2]), 4'(m_addr),
                     1'(m_state == 1), 1'(m_state inside {1, 2, 3, 4, 6}),
                     1'(m_state == 5), 3'(m_state)};
            act_v = {x_out, y_out, z_out, mem_addr, mem_rd_en, busy, done, state_dbg};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int k = 0;
        while (state_dbg !== 3'(s) && k < budget) begin @(negedge clk); k++; end
        check("wait_state", 32'(state_dbg), 32'(s));
    endtask

    task automatic wait_ticks(input int n);
        int t0 = m_ticks;
        int k = 0;
        while (m_ticks < t0 + n && k < (n + 1) * TD) begin @(negedge clk); k++; end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0;
    endtask

    function automatic logic [29:0] pose(input int x, input int y, input int z);
        return {10'(x), 10'(y), 10'(z)};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = pose(512, 512, 512);

        // Reset values
        cyc(3);
        check("rst_x", 32'(x_out), 512); check("rst_y", 32'(y_out), 512);
        check("rst_z", 32'(z_out), 512); check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0); check("rst_state", 32'(state_dbg), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        rst = 1'b0;

        // Single pose ramp, then full two-pose sequence
        mem[0] = pose(520, 500, 512);
        mem[1] = pose(512, 512, 512);
        pulse_start();
        check("fetch_rd_en", 32'(mem_rd_en), 1); check("fetch_addr", 32'(mem_addr), 0);
        wait_state(3, 10);
        wait_ticks(2);
        check("ramp2_x", 32'(x_out), 520); check("ramp2_y", 32'(y_out), 504);
        wait_ticks(1);
        check("ramp3_y", 32'(y_out), 500); check("ramp3_z", 32'(z_out), 512);
        wait_state(4, 5);
        wait_state(1, 4 * TD);
        check("fetch1_addr", 32'(mem_addr), 1);
        wait_state(5, 60 * TD);
        check("done_pulse", 32'(done), 1); check("done_busy", 32'(busy), 0);
        cyc(1);
        check("done_clear", 32'(done), 0); check("done_idle", 32'(state_dbg), 0);

        // Live follow
        accel_x = 10'd0; accel_y = 10'd1023; accel_z = 10'd515;
        select_source = 1'b1;
        wait_state(6, 5);
        wait_ticks(1);
        check("live_x", 32'(x_out), 508); check("live_y", 32'(y_out), 516);
        check("live_z", 32'(z_out), 515);
        pulse_start();
        check("live_start_ignored", 32'(state_dbg), 6);
        select_source = 1'b0;
        cyc(1);
        check("live_exit", 32'(state_dbg), 0); check("live_hold_x", 32'(x_out), 508);
        cyc(15);
        check("idle_hold_y", 32'(y_out), 516);

        // Stop mid-ramp
        do_reset();
        mem[0] = pose(1000, 0, 1000);
        pulse_start();
        wait_state(3, 10);
        wait_ticks(5);
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("stop_state", 32'(state_dbg), 0); check("stop_x", 32'(x_out), 532);
        check("stop_y", 32'(y_out), 492); check("stop_z", 32'(z_out), 532);
        check("stop_no_done", 32'(done), 0);
        cyc(20);
        check("stop_freeze_x", 32'(x_out), 532);
        pulse_start();
        check("restart_state", 32'(state_dbg), 1); check("restart_addr", 32'(mem_addr), 0);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        check("start_stop_same", 32'(state_dbg), 0);
        pulse_start();
        check("restart2", 32'(state_dbg), 1);
        cyc(1); stop = 1'b1; cyc(1); stop = 1'b0;

        // Pose equal to outputs: one cycle of RAMP; reset beats start in DWELL
        do_reset();
        mem[0] = pose(512, 512, 512);
        pulse_start();
        cyc(2);
        check("eq_ramp", 32'(state_dbg), 3);
        cyc(1);
        check("eq_dwell", 32'(state_dbg), 4);
        rst = 1'b1; start = 1'b1; cyc(1); rst = 1'b0; start = 1'b0;
        check("prio_state", 32'(state_dbg), 0); check("prio_busy", 32'(busy), 0);
        check("prio_x", 32'(x_out), 512);

        // Randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 20000; n++) begin
            if (m_state == 0 && $urandom_range(0, 19) == 0)
                for (int a = 0; a < NP; a++) begin
                    int v[3];
                    for (int i = 0; i < 3; i++)
                        v[i] = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 1023 : 0)
                                                           : $urandom_range(440, 580);
                    mem[a] = ($urandom_range(0, 7) == 0) ? pose(m_out[0], m_out[1], m_out[2])
                                                         : pose(v[0], v[1], v[2]);
                end
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 799) == 0) select_source = ~select_source;
            if ($urandom_range(0, 49) == 0) begin
                accel_x = 10'($urandom_range(0, 1023));
                accel_y = 10'($urandom_range(0, 1023));
                accel_z = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 4999) == 0) rst = 1'b1; else rst = 1'b0;
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
